// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the direct-mapped BTB: counter encodings,
// default geometry and per-entry field widths.
package branch_predictor_btb_pkg;

    localparam int ENTRY_BITS_DEFAULT = 6;
    localparam int PC_BITS            = 32;
    localparam int TARGET_BITS        = 32;
    localparam int CTR_BITS           = 2;

    localparam logic [CTR_BITS-1:0] SNT = 2'b00;
    localparam logic [CTR_BITS-1:0] WNT = 2'b01;
    localparam logic [CTR_BITS-1:0] WT  = 2'b10;
    localparam logic [CTR_BITS-1:0] ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// 2-bit saturating history counter next-state function.
module sat_counter2
    import branch_predictor_btb_pkg::*;
(
    input  logic [CTR_BITS-1:0] state,
    input  logic                taken,
    output logic [CTR_BITS-1:0] next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != ST) next_state = state + 2'd1;
        end else begin
            if (state != SNT) next_state = state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit history counters:
// combinational IF lookup, EX-side update, mispredict detection, perf counters.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int ENTRY_BITS = ENTRY_BITS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_BITS-1:0]     pc_if,
    output logic                   pred_taken,
    output logic [TARGET_BITS-1:0] pred_target,
    input  logic                   stall_ex,
    input  logic                   ex_valid,
    input  logic                   ex_is_branch,
    input  logic [PC_BITS-1:0]     ex_pc,
    input  logic                   ex_br,
    input  logic [TARGET_BITS-1:0] ex_target,
    input  logic                   ex_pred_taken,
    input  logic [TARGET_BITS-1:0] ex_pred_target,
    output logic                   mispredict,
    output logic [PC_BITS-1:0]     redirect_pc,
    output logic [31:0]            br_count,
    output logic [31:0]            mispred_count
);

    localparam int TAG_BITS = 30 - ENTRY_BITS;
    localparam int ENTRIES  = 1 << ENTRY_BITS;

    logic                   valid_arr  [ENTRIES];
    logic [TAG_BITS-1:0]    tag_arr    [ENTRIES];
    logic [TARGET_BITS-1:0] target_arr [ENTRIES];
    logic [CTR_BITS-1:0]    ctr_arr    [ENTRIES];

    logic [ENTRY_BITS-1:0]  if_idx;
    logic [TAG_BITS-1:0]    if_tag;
    logic [ENTRY_BITS-1:0]  ex_idx;
    logic [TAG_BITS-1:0]    ex_tag;
    logic                   if_hit;
    logic                   ex_hit;
    logic                   upd;
    logic [CTR_BITS-1:0]    ex_ctr;
    logic [CTR_BITS-1:0]    ex_ctr_next;
    logic                   unused_pc_bits;

    logic [31:0]            br_count_reg;
    logic [31:0]            mispred_count_reg;

    assign if_idx = pc_if[ENTRY_BITS+1:2];
    assign if_tag = pc_if[31:ENTRY_BITS+2];
    assign ex_idx = ex_pc[ENTRY_BITS+1:2];
    assign ex_tag = ex_pc[31:ENTRY_BITS+2];
    assign unused_pc_bits = ^pc_if[1:0];

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        if_hit      = valid_arr[if_idx] && (tag_arr[if_idx] == if_tag);
        pred_taken  = !rst && if_hit && ctr_arr[if_idx][1];
        pred_target = pred_taken ? target_arr[if_idx] : '0;
    end

    assign upd    = ex_valid && ex_is_branch && !stall_ex;
    assign ex_hit = valid_arr[ex_idx] && (tag_arr[ex_idx] == ex_tag);
    assign ex_ctr = ctr_arr[ex_idx];

    sat_counter2 u_sat_counter2 (
        .state      (ex_ctr),
        .taken      (ex_br),
        .next_state (ex_ctr_next)
    );

    assign mispredict  = upd && ((ex_br != ex_pred_taken) ||
                                 (ex_br && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_br ? ex_target : ex_pc + 32'd4;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                   valid_reg;
            logic [TAG_BITS-1:0]    tag_reg;
            logic [TARGET_BITS-1:0] target_reg;
            logic [CTR_BITS-1:0]    ctr_reg;
            logic                   we;

            assign we = upd && (ex_idx == ENTRY_BITS'(gi));

            // A miss allocates only when taken; a not-taken miss leaves the entry alone.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= WNT;
                end else if (we) begin
                    if (ex_hit) begin
                        ctr_reg <= ex_ctr_next;
                        if (ex_br) target_reg <= ex_target;
                    end else if (ex_br) begin
                        valid_reg  <= 1'b1;
                        tag_reg    <= ex_tag;
                        target_reg <= ex_target;
                        ctr_reg    <= WT;
                    end
                end
            end

            assign valid_arr[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else if (upd) begin
            br_count_reg <= br_count_reg + 32'd1;
            if (mispredict) mispred_count_reg <= mispred_count_reg + 32'd1;
        end
    end

    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall_ex;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_br;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.ENTRY_BITS(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_if          (pc_if),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .stall_ex       (stall_ex),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_br          (ex_br),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    // Reference model: 64 entries, counter kept as an integer strength 0..3.
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    logic [31:0] m_target [64];
    int          m_ctr    [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / 256;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_target[i] = '0;
            m_ctr[i]   = 1;
        end
        m_br  = '0;
        m_mis = '0;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit exp_pred_taken(input logic [31:0] pc);
        return model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] exp_pred_target(input logic [31:0] pc);
        return exp_pred_taken(pc) ? m_target[idx_of(pc)] : 32'd0;
    endfunction

    function automatic bit exp_upd();
        return ex_valid && ex_is_branch && !stall_ex;
    endfunction

    function automatic bit exp_mispredict();
        return exp_upd() && ((ex_br != ex_pred_taken) ||
                             (ex_br && ex_pred_target != ex_target));
    endfunction

    function automatic logic [31:0] exp_redirect();
        return ex_br ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic drive(input bit v, input bit b, input logic [31:0] pc, input bit br,
                         input logic [31:0] tgt, input bit pt, input logic [31:0] ptg,
                         input bit st);
        ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_br = br;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg; stall_ex = st;
    endtask

    task automatic idle();
        drive(0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0);
    endtask

    // Advance one clock; the model absorbs whatever EX presented before the edge.
    task automatic step();
        bit          u, mis, br;
        int          i;
        int unsigned t;
        logic [31:0] tgt;
        u = exp_upd(); mis = exp_mispredict(); br = ex_br;
        i = idx_of(ex_pc); t = tag_of(ex_pc); tgt = ex_target;
        @(posedge clk);
        if (u) begin
            m_br = m_br + 32'd1;
            if (mis) m_mis = m_mis + 32'd1;
            if (m_valid[i] && m_tag[i] == t) begin
                m_ctr[i] = br ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (br) m_target[i] = tgt;
            end else if (br) begin
                m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = tgt; m_ctr[i] = 2;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); pc_if = 32'h100;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
        n_cmp++; if (pred_target !== 32'd0) begin n_bad++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
        rst = 1'b0;
        #2;
        n_cmp++; if (br_count !== 32'd0) begin n_bad++; $display("FAIL reset_br_count: got %0d want 0", br_count); end
        n_cmp++; if (mispred_count !== 32'd0) begin n_bad++; $display("FAIL reset_mis_count: got %0d want 0", mispred_count); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL post_reset_lookup: got %b want 0", pred_taken); end
        @(posedge clk); #1;
        $display("reset: pred_taken=%b br_count=%0d mispred_count=%0d", pred_taken, br_count, mispred_count);
    endtask

    task automatic test_taken_alloc();
        drive(1, 1, 32'h100, 1, 32'h80, 0, 32'd0, 0); pc_if = 32'h100;
        #2;
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL alloc_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h80) begin n_bad++; $display("FAIL alloc_redirect: got %h want 00000080", redirect_pc); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL alloc_same_cycle_lookup: got %b want 0", pred_taken); end
        step(); idle(); #2;
        n_cmp++; if (pred_taken !== 1'b1) begin n_bad++; $display("FAIL alloc_pred_taken: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h80) begin n_bad++; $display("FAIL alloc_pred_target: got %h want 00000080", pred_target); end
        n_cmp++; if (br_count !== 32'd1) begin n_bad++; $display("FAIL alloc_br_count: got %0d want 1", br_count); end
        n_cmp++; if (mispred_count !== 32'd1) begin n_bad++; $display("FAIL alloc_mis_count: got %0d want 1", mispred_count); end
        @(posedge clk); #1;
        $display("taken_alloc: pc=00000100 pred_taken=%b pred_target=%h", pred_taken, pred_target);
    endtask

    task automatic test_not_taken();
        drive(1, 1, 32'h100, 0, 32'h80, 1, 32'h80, 0); pc_if = 32'h100;
        #2;
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL nt1_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h104) begin n_bad++; $display("FAIL nt1_redirect: got %h want 00000104", redirect_pc); end
        step(); idle(); #2;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL nt1_pred_taken: got %b want 0", pred_taken); end
        drive(1, 1, 32'h100, 0, 32'h80, 0, 32'd0, 0); #2;
        n_cmp++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL nt2_mispredict: got %b want 0", mispredict); end
        step();
        // Entry must still be valid at SNT: a taken resolution only lifts it to WNT.
        drive(1, 1, 32'h100, 1, 32'h80, 0, 32'd0, 0); step(); idle(); #2;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL nt_entry_kept: got %b want 0", pred_taken); end
        n_cmp++; if (mispred_count !== m_mis) begin n_bad++; $display("FAIL nt_mis_count: got %0d want %0d", mispred_count, m_mis); end
        @(posedge clk); #1;
        $display("not_taken: pc=00000100 pred_taken=%b br_count=%0d", pred_taken, br_count);
    endtask

    task automatic test_alias();
        drive(1, 1, 32'h100, 1, 32'h180, 0, 32'd0, 0); step();
        drive(1, 1, 32'h200, 1, 32'h240, 0, 32'd0, 0); step(); idle();
        pc_if = 32'h100; #2;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL alias_old_miss: got %b want 0", pred_taken); end
        pc_if = 32'h200; #2;
        n_cmp++; if (pred_taken !== 1'b1) begin n_bad++; $display("FAIL alias_new_hit: got %b want 1", pred_taken); end
        n_cmp++; if (pred_target !== 32'h240) begin n_bad++; $display("FAIL alias_new_target: got %h want 00000240", pred_target); end
        @(posedge clk); #1;
        $display("alias: pc=00000200 pred_taken=%b pred_target=%h", pred_taken, pred_target);
    endtask

    task automatic test_target_mismatch();
        drive(1, 1, 32'h200, 1, 32'h80, 1, 32'h84, 0); pc_if = 32'h200; #2;
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL tgt_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (redirect_pc !== 32'h80) begin n_bad++; $display("FAIL tgt_redirect: got %h want 00000080", redirect_pc); end
        step(); idle(); #2;
        n_cmp++; if (pred_target !== 32'h80) begin n_bad++; $display("FAIL tgt_updated: got %h want 00000080", pred_target); end
        @(posedge clk); #1;
        $display("target_mismatch: pc=00000200 pred_target=%h", pred_target);
    endtask

    task automatic test_stall();
        logic [31:0] br0, mis0;
        br0 = m_br; mis0 = m_mis;
        drive(1, 1, 32'h300, 1, 32'h3c0, 0, 32'd0, 1); pc_if = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_cmp++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL stall_mispredict c%0d: got %b want 0", c, mispredict); end
            step();
            n_cmp++; if (br_count !== br0 || mispred_count !== mis0) begin n_bad++; $display("FAIL stall_counts c%0d: got %0d/%0d want %0d/%0d", c, br_count, mispred_count, br0, mis0); end
            n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL stall_no_alloc c%0d: got %b want 0", c, pred_taken); end
        end
        stall_ex = 1'b0; #2;
        n_cmp++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL unstall_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL unstall_old_lookup: got %b want 0", pred_taken); end
        step(); idle(); #2;
        n_cmp++; if (pred_taken !== 1'b1 || pred_target !== 32'h3c0) begin n_bad++; $display("FAIL unstall_new_lookup: got %b/%h want 1/000003c0", pred_taken, pred_target); end
        n_cmp++; if (br_count !== br0 + 32'd1) begin n_bad++; $display("FAIL unstall_br_count: got %0d want %0d", br_count, br0 + 32'd1); end
        @(posedge clk); #1;
        $display("stall: br_count=%0d mispred_count=%0d", br_count, mispred_count);
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 32'h300, 1, 32'h500, 0, 32'd0, 0); pc_if = 32'h300;
        #2; rst = 1'b1; #1;
        n_cmp++; if (br_count !== 32'd0 || mispred_count !== 32'd0) begin n_bad++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", br_count, mispred_count); end
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL midrst_lookup: got %b want 0", pred_taken); end
        model_reset();
        @(posedge clk); #3;
        rst = 1'b0; idle(); #1;
        pc_if = 32'h200; #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_bad++; $display("FAIL midrst_cleared_200: got %b want 0", pred_taken); end
        @(posedge clk); #1;
        pc_if = 32'h300; #1;
        n_cmp++; if (pred_taken !== 1'b0 || br_count !== 32'd0) begin n_bad++; $display("FAIL midrst_no_update: got %b/%0d want 0/0", pred_taken, br_count); end
        @(posedge clk); #1;
        $display("reset_mid: pred_taken=%b br_count=%0d", pred_taken, br_count);
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned tsel, isel;
        logic [31:0] tg, ix;
        tsel = $urandom_range(0, 3);
        isel = $urandom_range(0, 8);
        tg = (tsel == 3) ? 32'h00ff_ffff : 32'(tsel);
        ix = (isel == 8) ? 32'd63 : 32'(isel);
        return (tg * 256) + (ix * 4);
    endfunction

    task automatic test_random();
        logic [31:0] p;
        bit ep; logic [31:0] et; bit em; logic [31:0] er;
        for (int n = 0; n < 200; n++) begin
            pc_if = rand_pc();
            p = rand_pc();
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), p,
                  1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4,
                  1'b0, 32'd0, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken = exp_pred_taken(p); ex_pred_target = exp_pred_target(p);
            end else begin
                ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
            end
            #2;
            ep = exp_pred_taken(pc_if); et = exp_pred_target(pc_if);
            em = exp_mispredict(); er = exp_redirect();
            n_cmp++; if (pred_taken !== ep || pred_target !== et) begin n_bad++; $display("FAIL rnd_lookup n%0d: got %b/%h want %b/%h", n, pred_taken, pred_target, ep, et); end
            n_cmp++; if (mispredict !== em || redirect_pc !== er) begin n_bad++; $display("FAIL rnd_ex n%0d: got %b/%h want %b/%h", n, mispredict, redirect_pc, em, er); end
            step();
            n_cmp++; if (br_count !== m_br || mispred_count !== m_mis) begin n_bad++; $display("FAIL rnd_counts n%0d: got %0d/%0d want %0d/%0d", n, br_count, mispred_count, m_br, m_mis); end
            $display("rnd %0d: pc_if=%h ex_pc=%h br=%b mis=%b counts=%0d/%0d", n, pc_if, p, ex_br, em, br_count, mispred_count);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_taken_alloc();
        test_not_taken();
        test_alias();
        test_target_mismatch();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
